// File: rtl/jtframe_pkg.sv
// Shared jtframe package.
// Holds the 2-bit state encoding used by the clock-domain-crossing
// transmitter FSM (IDLE=0, LOAD=1, WAIT=2).
package jtframe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } cdc_state_e;

endpackage

// File: rtl/jtframe_cdc_tx_if.sv
// Handshake/bus bundle for jtframe_cdc_tx.
//   din/din_valid/din_ready : near-domain word input with ready/valid
//   dout/req                : word and 2-phase request toward far domain
//   ack_raw                 : 2-phase ack from far domain (asynchronous)
//   busy/err                : status (transfer in progress / sticky timeout)
// slave  : view used by the transmitter block
// master : view used by the producer / far-end model
interface jtframe_cdc_tx_if #(
  parameter int W = 8
);
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic [W-1:0] dout;
  logic         req;
  logic         ack_raw;
  logic         busy;
  logic         err;

  modport master (
    output din, din_valid, ack_raw,
    input  din_ready, dout, req, busy, err
  );

  modport slave (
    input  din, din_valid, ack_raw,
    output din_ready, dout, req, busy, err
  );
endinterface

// File: rtl/jtframe_sync.sv
// Multi-bit flop synchronizer: two flops in the destination clock,
// optionally preceded by an input register (LATCHIN=1).
// Ports: clk, rst_n (async active-low), din (async input), dout (synced).
module jtframe_sync #(
  parameter int W       = 1,
  parameter int LATCHIN = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] w_in;
  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  generate
    if (LATCHIN != 0) begin : g_latchin
      logic [W-1:0] r_in;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_in <= '0;
        else        r_in <= din;
      end
      assign w_in = r_in;
    end else begin : g_direct
      assign w_in = din;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_in;
      r_s2 <= r_s1;
    end
  end

  assign dout = r_s2;
endmodule

// File: rtl/jtframe_cdc_tx.sv
// Clock-domain-crossing transmitter with a 2-phase req/ack handshake.
// A one-entry buffer accepts words (din_ready = !buf_full); the FSM copies
// the buffer to dout, toggles req one cycle later so dout is already
// stable, then waits for the synchronized ack to match req. A saturating
// counter flags a sticky err if the ack takes 2^TOW-1 cycles or more.
// Ports: clk, rst_n (async active-low), bus (jtframe_cdc_tx_if.slave).
module jtframe_cdc_tx
  import jtframe_pkg::*;
#(
  parameter int W   = 8,
  parameter int TOW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  jtframe_cdc_tx_if.slave  bus
);
  cdc_state_e     r_state;
  cdc_state_e     w_state_nxt;
  logic [W-1:0]   r_buf;
  logic           r_buf_full;
  logic [W-1:0]   r_dout;
  logic           r_req;
  logic [TOW-1:0] r_cnt;
  logic [TOW-1:0] w_cnt_inc;
  logic           r_err;
  logic           w_ack_s;
  logic           w_acc;
  logic           w_drain;
  logic           w_toggle;

  jtframe_sync #(.W(1), .LATCHIN(0)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.ack_raw),
    .dout  (w_ack_s)
  );

  assign w_acc     = bus.din_valid & ~r_buf_full;
  assign w_cnt_inc = r_cnt + TOW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_drain     = 1'b0;
    w_toggle    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_buf_full) begin
          w_drain     = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_toggle    = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // ack changes are only looked at here; elsewhere they are ignored
        if (w_ack_s == r_req) begin
          if (r_buf_full) begin
            w_drain     = 1'b1;
            w_state_nxt = ST_LOAD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_dout     <= '0;
      r_req      <= 1'b0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_acc) r_buf <= bus.din;
      // accept needs an empty buffer and drain a full one, so they never collide
      if (w_acc)        r_buf_full <= 1'b1;
      else if (w_drain) r_buf_full <= 1'b0;
      if (w_drain) r_dout <= r_buf;
      if (w_toggle) begin
        r_req <= ~r_req;
        r_cnt <= '0;
      end else if (r_state == ST_WAIT && r_cnt != '1) begin
        r_cnt <= w_cnt_inc;
      end
      // err is sticky: no retransmit, a late ack still completes normally
      if (r_state == ST_WAIT && r_cnt != '1 && w_cnt_inc == '1) r_err <= 1'b1;
    end
  end

  assign bus.din_ready = ~r_buf_full;
  assign bus.dout      = r_dout;
  assign bus.req       = r_req;
  assign bus.busy      = (r_state != ST_IDLE) | r_buf_full;
  assign bus.err       = r_err;
endmodule
